// File: rtl/freq_meter_if.sv
// Bundle between the frequency meter and its user: enable and signal in,
// measurement result, strobe and status out.
`timescale 1ns/1ps
interface freq_meter_if #(
    parameter int CNT_W = 27
);
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] freq;
    logic             freq_valid;
    logic             overflow;
    logic             busy;

    modport master (
        output en, sig_in,
        input  freq, freq_valid, overflow, busy
    );

    modport slave (
        input  en, sig_in,
        output freq, freq_valid, overflow, busy
    );
endinterface

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed window of clk
// cycles and publishes the count with a one-cycle valid strobe.
`timescale 1ns/1ps
module freq_meter #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_W       = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    freq_meter_if.slave   bus
);
    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GATE  = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  freq_q, freq_d;
    logic              overflow_q, overflow_d;
    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;

    logic              edge_det;
    logic [CNT_W-1:0]  edge_next;
    logic              sat_next;

    always_comb begin
        s1_d     = bus.sig_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        edge_det = s2_q & ~s3_q;

        // Count including this cycle's edge, so the final gate cycle is not lost.
        edge_next = edge_cnt_q;
        sat_next  = sat_q;
        if (edge_det) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                edge_next = edge_cnt_q + CNT_W'(1);
            end
        end

        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        freq_d     = freq_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d    = GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end
            end
            GATE: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    edge_cnt_d = edge_next;
                    sat_d      = sat_next;
                    // Result is loaded on entry to LATCH so freq changes with freq_valid.
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d    = LATCH;
                        freq_d     = edge_next;
                        overflow_d = sat_next;
                    end
                end
            end
            LATCH: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                state_d    = bus.en ? GATE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            overflow_q <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            overflow_q <= overflow_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
        end
    end

    assign bus.freq       = freq_q;
    assign bus.overflow   = overflow_q;
    assign bus.freq_valid = (state_q == LATCH);
    assign bus.busy       = (state_q == GATE);
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: expected results are queued by the
// stimulus and checked by monitors on every freq_valid strobe.
`timescale 1ns/1ps
module tb_freq_meter;
    typedef struct {
        int lo;
        int hi;
        int ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sig = 1'b0;
    int   half_ns = 0;
    logic dc_level = 1'b0;

    int   total = 0;
    int   bad = 0;
    exp_t q_main[$];
    exp_t q_sat[$];

    freq_meter_if #(.CNT_W(27)) m_if ();
    freq_meter_if #(.CNT_W(6))  s_if ();

    freq_meter #(.CLK_HZ(100_000_000), .GATE_CYCLES(1000), .CNT_W(27)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    freq_meter #(.CLK_HZ(100_000_000), .GATE_CYCLES(1000), .CNT_W(6)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    always #5 clk = ~clk;

    assign m_if.sig_in = sig;
    assign s_if.sig_in = sig;

    // Input generator, offset 3 ns from the clock grid so edges are asynchronous.
    initial begin
        #3;
        forever begin
            if (half_ns == 0) begin
                sig = dc_level;
                #1;
            end else begin
                #(half_ns);
                sig = ~sig;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push_main(input int lo, input int hi, input int ovf);
        exp_t e;
        e.lo = lo; e.hi = hi; e.ovf = ovf;
        q_main.push_back(e);
    endtask

    task automatic push_sat(input int lo, input int hi, input int ovf);
        exp_t e;
        e.lo = lo; e.hi = hi; e.ovf = ovf;
        q_sat.push_back(e);
    endtask

    task automatic wait_valid(input bit use_sat, input int budget, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if ((use_sat ? s_if.freq_valid : m_if.freq_valid) == 1'b1) break;
            if (cycles >= budget) begin
                check(use_sat ? "sat_valid_timeout" : "main_valid_timeout", cycles, 0, budget - 1);
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (m_if.freq_valid) begin
            check("main_expected_pending", q_main.size(), 1, 1000);
            if (q_main.size() > 0) begin
                e = q_main.pop_front();
                check("main_freq", int'(m_if.freq), e.lo, e.hi);
                check("main_overflow", int'(m_if.overflow), e.ovf, e.ovf);
                $display("main result: freq=%0d overflow=%0d", m_if.freq, m_if.overflow);
            end
        end
        if (s_if.freq_valid) begin
            check("sat_expected_pending", q_sat.size(), 1, 1000);
            if (q_sat.size() > 0) begin
                e = q_sat.pop_front();
                check("sat_freq", int'(s_if.freq), e.lo, e.hi);
                check("sat_overflow", int'(s_if.overflow), e.ovf, e.ovf);
                $display("sat result: freq=%0d overflow=%0d", s_if.freq, s_if.overflow);
            end
        end
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        m_if.en   = 1'b0;
        s_if.en   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_freq", int'(m_if.freq), 0, 0);
        check("reset_valid", int'(m_if.freq_valid), 0, 0);
        check("reset_overflow", int'(m_if.overflow), 0, 0);
        check("reset_busy", int'(m_if.busy), 0, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Period 10 clk, two back-to-back windows.
        half_ns = 50;
        repeat (20) @(negedge clk);
        push_main(99, 101, 0);
        push_main(99, 101, 0);
        m_if.en = 1'b1;
        wait_valid(1'b0, 1100, cyc);
        check("t1_latency", cyc, 1001, 1004);
        wait_valid(1'b0, 1100, cyc);
        check("t1_period", cyc, 1001, 1001);
        m_if.en = 1'b0;

        // Fastest input: period 2 clk.
        half_ns = 10;
        repeat (20) @(negedge clk);
        push_main(499, 501, 0);
        push_main(499, 501, 0);
        m_if.en = 1'b1;
        wait_valid(1'b0, 1100, cyc);
        wait_valid(1'b0, 1100, cyc);
        check("t2_period", cyc, 1001, 1001);
        m_if.en = 1'b0;

        // Abort mid-gate: no result, prior value held, then a fresh window.
        half_ns = 50;
        repeat (20) @(negedge clk);
        m_if.en = 1'b1;
        repeat (500) @(negedge clk);
        check("t4_busy_mid", int'(m_if.busy), 1, 1);
        m_if.en = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_busy_abort", int'(m_if.busy), 0, 0);
        repeat (1100) @(negedge clk);
        check("t4_freq_held", int'(m_if.freq), 499, 501);
        check("t4_overflow_held", int'(m_if.overflow), 0, 0);
        push_main(99, 101, 0);
        m_if.en = 1'b1;
        wait_valid(1'b0, 1100, cyc);
        check("t4_reenable_latency", cyc, 1001, 1004);
        m_if.en = 1'b0;

        // Asynchronous reset mid-gate.
        repeat (10) @(negedge clk);
        m_if.en = 1'b1;
        repeat (300) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_freq_in_reset", int'(m_if.freq), 0, 0);
        check("t5_busy_in_reset", int'(m_if.busy), 0, 0);
        repeat (2) @(negedge clk);
        push_main(99, 101, 0);
        rst_n = 1'b1;
        wait_valid(1'b0, 1100, cyc);
        check("t5_after_reset_latency", cyc, 1001, 1004);
        m_if.en = 1'b0;

        // Saturation on the 6-bit instance, then a normal window.
        half_ns = 20;
        repeat (20) @(negedge clk);
        push_sat(63, 63, 1);
        s_if.en = 1'b1;
        wait_valid(1'b1, 1100, cyc);
        check("t3_sat_latency", cyc, 1001, 1004);
        s_if.en = 1'b0;
        half_ns = 500;
        repeat (250) @(negedge clk);
        push_sat(9, 11, 0);
        s_if.en = 1'b1;
        wait_valid(1'b1, 1100, cyc);
        s_if.en = 1'b0;

        // DC input: zero counts, then a long idle stretch with no strobe.
        dc_level = 1'b1;
        half_ns  = 0;
        repeat (20) @(negedge clk);
        push_main(0, 0, 0);
        push_main(0, 0, 0);
        m_if.en = 1'b1;
        wait_valid(1'b0, 1100, cyc);
        wait_valid(1'b0, 1100, cyc);
        m_if.en = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_busy_idle", int'(m_if.busy), 0, 0);
        repeat (5000) @(negedge clk);
        check("t6_busy_after_5000", int'(m_if.busy), 0, 0);

        check("main_queue_drained", q_main.size(), 0, 0);
        check("sat_queue_drained", q_sat.size(), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Measures the frequency of an external asynchronous square wave, sig_in, by counting its rising edges over a fixed gate window. The gate window is timed from the system clock.
- This is the measuring counterpart to the team's clock dividers. It checks generated divided clocks (for example the 25 MHz pixel clock) or external inputs on the board.
- Results go to the seven-segment/display path as a binary count, with a one-cycle valid strobe.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency in Hz; documentation only, sets the GATE_CYCLES default.
- GATE_CYCLES, 100_000_000: gate window length in clk cycles (default 1 s, so the result is in Hz).
- CNT_W, 27: width of the edge counter and of the freq output.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: measurement enable; level-sensitive.
- sig_in, input, 1: signal under test; asynchronous to clk.
- freq, output, CNT_W: last completed measurement (rising edges per gate).
- freq_valid, output, 1: one-cycle pulse when freq updates.
- overflow, output, 1: last completed measurement saturated.
- busy, output, 1: high while in GATE state.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - freq=0, freq_valid=0, overflow=0, busy=0.
  - State=IDLE.
  - Gate counter, edge counter and synchronizer flops all 0.
- Input path:
  - Two-flop synchronizer s1, s2, plus history flop s3.
  - edge_det = s2 & ~s3.
  - Latency from a sig_in rising edge to edge_det is 2–3 clk.
  - Only input periods of at least 2 clk are measured correctly; faster inputs alias.
- States:
  - IDLE: busy=0. When en=1, go to GATE next cycle, clearing the gate counter and edge counter.
  - GATE: busy=1.
    - Gate counter increments every cycle.
    - Edge counter increments on each edge_det cycle.
    - The gate is exactly GATE_CYCLES cycles: gate counter values 0 to GATE_CYCLES-1. An edge_det in the final gate cycle is counted.
    - After the final gate cycle, go to LATCH.
  - LATCH (1 cycle):
    - freq <= edge count; overflow <= saturation flag; freq_valid=1 for this one cycle; busy=0.
    - If en=1, go to GATE, clearing both counters: back-to-back windows, one dead cycle between gates.
    - If en=0, go to IDLE.
- Saturation: the edge counter stops at 2^CNT_W-1 and sets a saturation flag. The flag is cleared at the start of each gate.
- en deasserted during GATE:
  - Abort to IDLE on the next cycle.
  - No freq_valid; freq and overflow keep their previous values.
- Reset mid-gate: all state cleared immediately; no partial result is ever published.
- Between updates, freq is stable; it changes only in the freq_valid cycle.
- The gate counter is wide enough for GATE_CYCLES-1, computed as $clog2(GATE_CYCLES).

Test Plan (GATE_CYCLES=1000 unless noted):
1. Rate accuracy: en=1; sig_in period 10 clk, asynchronous phase → first freq_valid 1001–1004 cycles after en is seen; freq=100±1; overflow=0.
2. Fastest input: sig_in toggles every clk (period 2) → freq=500±1. Consecutive windows with en held high → freq_valid pulses exactly 1001 cycles apart.
3. Saturation: CNT_W=6, sig_in period 4 clk (≈250 edges) → freq=63, overflow=1. Next window at period 100 clk → freq=10, overflow=0.
4. Abort: en dropped at gate cycle 500 → busy falls; no freq_valid; freq keeps the prior value. Re-enable → fresh full window.
5. Reset mid-gate: rst_n pulsed low at gate cycle 300, asynchronously between clock edges → outputs 0 immediately. After release with en=1 → first result after a full window.
6. Idle/DC input: sig_in held high with en=1 → freq=0 each window. en=0 → busy=0 and no freq_valid for 5000 cycles.
